// File: rtl/alu_arbiter_pkg.sv
// Shared constants for alu_arbiter: opcode values, FSM state encoding and default widths.

package alu_arbiter_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned OPW_DEF   = 4;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_SLT  = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_LAST = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT(unsigned)/NOR; undefined opcodes drive zero.

module alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  always_comb begin
    y = '0;
    case (op)
      OPW'(OP_AND): y = a & b;
      OPW'(OP_OR):  y = a | b;
      OPW'(OP_ADD): y = a + b;
      OPW'(OP_SUB): y = a - b;
      OPW'(OP_SLT): y = WIDTH'(a < b);
      OPW'(OP_NOR): y = ~(a | b);
      default:      y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two valid/ready requesters.
// Optional ALU_ARBITER_ERR_EN adds a registered resp_err flag for opcodes >= 6.

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero
`ifdef ALU_ARBITER_ERR_EN
  ,
  output logic             resp_err
`endif
);

  state_t           state;
  logic             last;
  logic             owner;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             grant;
  logic             bad_op;

  // Tie goes to the requester not served last; otherwise the single valid one.
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = ~last;
  end

  assign bad_op = (op_q > OPW'(OP_LAST));

  // Handshake strobes are forced low while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (reset && state == ST_IDLE && (|req_valid)) req_ready[grant] = 1'b1;
  end

  always_comb begin
    resp_valid = 2'b00;
    if (reset && state == ST_RESP) resp_valid[owner] = 1'b1;
  end

  alu #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (alu_y),
    .zero(alu_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      resp_data <= '0;
      resp_zero <= 1'b0;
`ifdef ALU_ARBITER_ERR_EN
      resp_err  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            op_q  <= grant ? req_op1 : req_op0;
            a_q   <= grant ? req_a1 : req_a0;
            b_q   <= grant ? req_b1 : req_b0;
            owner <= grant;
            last  <= grant;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Undefined opcodes report zero regardless of what the ALU drives.
          resp_data <= bad_op ? '0 : alu_y;
          resp_zero <= bad_op ? 1'b1 : alu_zero;
`ifdef ALU_ARBITER_ERR_EN
          resp_err  <= bad_op;
`endif
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready[owner]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one `alu` instance between two requesters, for example the execute stage and the address-generation path.
- Each requester submits an opcode and two operands through a valid/ready handshake.
- The block arbitrates round-robin, registers the operation, evaluates it on the ALU and holds the registered result until the winning requester accepts it.
- It sits between the datapath requesters and the ALU, and is the only driver of the ALU inputs.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.
- `OPW`, default 4: opcode width; matches the ALU control input.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `req_valid[1:0]` in 2: requester i presents an operation.
- `req_ready[1:0]` out 2: requester i's operation is accepted this cycle.
- `req_op0`, `req_op1` in OPW: opcode, 0=AND, 1=OR, 2=ADD, 3=SUB, 4=SLT (unsigned), 5=NOR.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in WIDTH: operands.
- `resp_valid[1:0]` out 2: result for requester i is available.
- `resp_ready[1:0]` in 2: requester i takes its result.
- `resp_data` out WIDTH: registered ALU result.
- `resp_zero` out 1: registered ALU zero flag.
- `resp_err` out 1: present only with `ALU_ARBITER_ERR_EN` (see Configuration).

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: the ALU evaluates the registered operands.
  - RESP: the result is held.
- IDLE:
  - grant = requester with `req_valid` high.
  - If both are valid, grant the requester not served last. The `last` register resets to 1, so requester 0 wins the first tie.
  - `req_ready[grant]` = 1 (combinational, IDLE only). The other bit is 0.
  - On handshake: capture op, a and b into operand registers; capture grant into `owner`; update `last`; go to EXEC.
- EXEC:
  - ALU inputs come only from the operand registers.
  - At the end of the cycle, register the ALU result and zero flag into `resp_data`/`resp_zero`; go to RESP.
- RESP:
  - `resp_valid[owner]` = 1. `resp_data`/`resp_zero` are stable.
  - When `resp_ready[owner]` = 1, go to IDLE.
  - `resp_ready` of the non-owner is ignored.
- ALU inputs are held at the operand-register values outside EXEC, so they never float.
- Requester protocol: `req_valid` and the payload stay stable until `req_ready`. Dropping valid early is undefined and is not tested.
- Opcodes 6–15 (invalid): `resp_data` = 0 and `resp_zero` = 1, regardless of what the ALU drives.

## Timing
- Reset (`reset` low at an edge):
  - state = IDLE; `last` = 1; `owner` = 0; operand registers = 0.
  - `resp_data` = 0, `resp_zero` = 0, `resp_err` = 0.
  - `req_ready` = 0 and `resp_valid` = 0 while `reset` is low.
- Reset mid-operation abandons the operation; no response is ever issued for it.
- Latency:
  - Handshake at edge T; result registered at T+1.
  - `resp_valid` high in the cycle after edge T+1, i.e. 2 cycles after acceptance.
- Minimum occupancy is 3 cycles per operation. Peak throughput is one operation per 3 cycles.
- While the ALU is busy (EXEC or RESP), `req_ready` = 00.
- Response stall: RESP holds indefinitely; the other requester waits.
- A response handshake and a new acceptance can never happen in the same cycle.
- Width rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT returns 1 in bit 0, other bits 0.

## Configuration
- `ALU_ARBITER_ERR_EN` defined:
  - `resp_err` port exists.
  - It is registered with the result and is 1 exactly when the captured opcode is ≥ 6.
- `ALU_ARBITER_ERR_EN` undefined:
  - Port and logic are absent.
  - Invalid opcodes still return data 0 and zero 1, silently.

## Structure
- Package `alu_arbiter_pkg` holds:
  - opcode constants `OP_AND`..`OP_NOR` and `OP_LAST` = 5;
  - FSM state encoding `ST_IDLE`, `ST_EXEC`, `ST_RESP`;
  - default `WIDTH`/`OPW`.
- One sub-module, the existing `alu`, instantiated once.
  - Arbitration, FSM and result registers stay in `alu_arbiter`.

## Test plan
- Reset, then requester 0 issues ADD(5,7) → `req_ready[0]`=1 for one cycle; `resp_valid` = 01 two cycles later; `resp_data`=12, `resp_zero`=0.
- Both requesters valid in the same cycle with SUB(9,9) and OR(0xF0,0x0F) → requester 0 served first (data 0, zero 1); requester 1 served next (data 0xFF); the next tie goes to requester 0 again.
- Requester 1 holds `resp_ready`=0 for 5 cycles after SLT(3,8) → `resp_data`=1 stable throughout; requester 0's pending request gets `req_ready`=0 until the response handshake completes.
- ADD(0xFFFFFFFF,1) → `resp_data`=0, `resp_zero`=1. AND(0xFF00FF00,0x0FF00FF0) → 0x0F000F00.
- Opcode 9 → `resp_data`=0, `resp_zero`=1; with `ALU_ARBITER_ERR_EN`, `resp_err`=1; the following valid op returns `resp_err`=0.
- Pull `reset` low during EXEC → no `resp_valid`; after release, `req_ready` appears in IDLE and the tie-break restarts with requester 0.
